imm_gen_pipe: RTL and testbench

Parametrised, registered immediate generator for the decode stage. Takes a 32-bit instruction word and a format select, and produces the sign- or zero-extended immediate at XLEN width. Adds CSR zimm and shift-amount formats, plus an illegal-format/illegal-shamt flag with a saturating error counter. Sits between fetch/decode and the register-read stage, behind a valid/ready handshake with a two-entry skid buffer, so decode can stall without losing instructions or throughput.

---
 rtl/imm_gen_pipe.sv | 121 ++++++++++++
 tb/tb_imm_gen_pipe.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator with a valid/ready front end and a
// two-entry (output + skid) buffer so decode can stall without losing throughput.
module imm_gen_pipe #(
   parameter int XLEN     = 32,
   parameter int TAG_W    = 5,
   parameter int ERRCNT_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         in_instr,
   input  logic [2:0]          in_sel,
   input  logic [TAG_W-1:0]    in_tag,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [XLEN-1:0]     imm_out,
   output logic [TAG_W-1:0]    tag_out,
   output logic                err_out,
   output logic [ERRCNT_W-1:0] err_count
);

   typedef enum logic [2:0] {
      FMT_I  = 3'b000,
      FMT_S  = 3'b001,
      FMT_B  = 3'b010,
      FMT_U  = 3'b011,
      FMT_J  = 3'b100,
      FMT_Z  = 3'b101,
      FMT_SH = 3'b110,
      FMT_RS = 3'b111
   } fmt_e;

   logic [XLEN-1:0]  calc_imm;
   logic             calc_err;
   logic             skid_valid;
   logic [XLEN-1:0]  skid_imm;
   logic [TAG_W-1:0] skid_tag;
   logic             skid_err;
   logic             fire_in;
   logic             slot_free;
   logic             unused_opcode;

   // The opcode field is decoded upstream; only the immediate bits matter here.
   assign unused_opcode = ^in_instr[6:0];

   always_comb begin
      calc_imm = '0;
      calc_err = 1'b0;
      case (fmt_e'(in_sel))
         FMT_I:  calc_imm = XLEN'($signed(in_instr[31:20]));
         FMT_S:  calc_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
         FMT_B:  calc_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                           in_instr[11:8], 1'b0}));
         FMT_U:  calc_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
         FMT_J:  calc_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                           in_instr[30:21], 1'b0}));
         FMT_Z:  calc_imm = XLEN'(in_instr[19:15]);
         FMT_SH: begin
            // RV32 shifts only take 5 bits; a set bit 25 is an illegal shamt there.
            if (XLEN == 64) begin
               calc_imm = XLEN'(in_instr[25:20]);
            end else begin
               calc_imm = XLEN'(in_instr[24:20]);
               calc_err = in_instr[25];
            end
         end
         default: calc_err = 1'b1;
      endcase
   end

   // Ready depends only on the skid register, so out_ready never reaches in_ready.
   assign in_ready  = rst_n & ~skid_valid;
   assign fire_in   = in_valid & in_ready;
   assign slot_free = ~out_valid | out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         imm_out    <= '0;
         tag_out    <= '0;
         err_out    <= 1'b0;
         skid_valid <= 1'b0;
         skid_imm   <= '0;
         skid_tag   <= '0;
         skid_err   <= 1'b0;
         err_count  <= '0;
      end else begin
         if (slot_free) begin
            if (skid_valid) begin
               out_valid  <= 1'b1;
               imm_out    <= skid_imm;
               tag_out    <= skid_tag;
               err_out    <= skid_err;
               skid_valid <= fire_in;
               if (fire_in) begin
                  skid_imm <= calc_imm;
                  skid_tag <= in_tag;
                  skid_err <= calc_err;
               end
            end else begin
               out_valid <= fire_in;
               if (fire_in) begin
                  imm_out <= calc_imm;
                  tag_out <= in_tag;
                  err_out <= calc_err;
               end
            end
         end else if (fire_in) begin
            skid_valid <= 1'b1;
            skid_imm   <= calc_imm;
            skid_tag   <= in_tag;
            skid_err   <= calc_err;
         end
         if (fire_in && calc_err && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: format table on RV32/RV64 instances, then stall,
// skid, saturation and mid-flight reset sequences.
module tb_imm_gen_pipe;

   logic        clk;
   logic        rst_n;
   logic [31:0] instr;
   logic [2:0]  sel;
   logic [4:0]  tag;

   logic        v32, r32, ir32, ov32, err32;
   logic [31:0] imm32;
   logic [4:0]  tag32;
   logic [15:0] cnt32;

   logic        v64, r64, ir64, ov64, err64;
   logic [63:0] imm64;
   logic [4:0]  tag64;
   logic [15:0] cnt64;

   logic        ve, re, ire, ove, erre;
   logic [31:0] imme;
   logic [4:0]  tage;
   logic [1:0]  cnte;

   int checks;
   int errors;
   int recv;
   logic [4:0] exp_q[$];
   logic [15:0] exp_cnt32;
   logic [15:0] exp_cnt64;

   typedef struct {
      logic [31:0] instr;
      logic [2:0]  sel;
      logic [31:0] exp32;
      logic        err32;
      logic [63:0] exp64;
      logic        err64;
   } vec_t;

   vec_t vecs[15];

   imm_gen_pipe #(.XLEN(32), .TAG_W(5), .ERRCNT_W(16)) d32 (
      .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(ir32), .in_instr(instr),
      .in_sel(sel), .in_tag(tag), .out_valid(ov32), .out_ready(r32), .imm_out(imm32),
      .tag_out(tag32), .err_out(err32), .err_count(cnt32));

   imm_gen_pipe #(.XLEN(64), .TAG_W(5), .ERRCNT_W(16)) d64 (
      .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(ir64), .in_instr(instr),
      .in_sel(sel), .in_tag(tag), .out_valid(ov64), .out_ready(r64), .imm_out(imm64),
      .tag_out(tag64), .err_out(err64), .err_count(cnt64));

   imm_gen_pipe #(.XLEN(32), .TAG_W(5), .ERRCNT_W(2)) de (
      .clk(clk), .rst_n(rst_n), .in_valid(ve), .in_ready(ire), .in_instr(instr),
      .in_sel(sel), .in_tag(tag), .out_valid(ove), .out_ready(re), .imm_out(imme),
      .tag_out(tage), .err_out(erre), .err_count(cnte));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One cycle on d32: I-format word whose immediate equals the tag.
   task automatic cycle(input logic iv, input logic [4:0] t, input logic ordy, output logic acc);
      logic [4:0] e;
      v32   = iv;
      tag   = t;
      sel   = 3'b000;
      instr = {7'b0, t, 20'h00093};
      r32   = ordy;
      chk("in_ready", {63'b0, ir32}, {63'b0, exp_q.size() < 2});
      chk("out_valid", {63'b0, ov32}, {63'b0, exp_q.size() > 0});
      acc = iv && ir32;
      if (ov32 && ordy) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out", 64'd1, 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("order_tag", {59'b0, tag32}, {59'b0, e});
            chk("order_imm", {32'b0, imm32}, {59'b0, e});
            recv++;
         end
      end
      if (acc) exp_q.push_back(t);
      step();
   endtask

   initial begin
      logic acc;
      int sent;
      logic [1:0] cnt_exp[5];
      checks    = 0;
      errors    = 0;
      recv      = 0;
      exp_cnt32 = '0;
      exp_cnt64 = '0;
      cnt_exp   = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

      vecs[0]  = '{32'hFFF00093, 3'd0, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0};
      vecs[1]  = '{32'hFE20AE23, 3'd1, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0};
      vecs[2]  = '{32'h00000463, 3'd2, 32'h00000008, 1'b0, 64'h0000000000000008, 1'b0};
      vecs[3]  = '{32'h123452B7, 3'd3, 32'h12345000, 1'b0, 64'h0000000012345000, 1'b0};
      vecs[4]  = '{32'h001000EF, 3'd4, 32'h00000800, 1'b0, 64'h0000000000000800, 1'b0};
      vecs[5]  = '{32'h000FD073, 3'd5, 32'h0000001F, 1'b0, 64'h000000000000001F, 1'b0};
      vecs[6]  = '{32'h03F09093, 3'd6, 32'h0000001F, 1'b1, 64'h000000000000003F, 1'b0};
      vecs[7]  = '{32'hFFFFFFFF, 3'd7, 32'h00000000, 1'b1, 64'h0000000000000000, 1'b1};
      vecs[8]  = '{32'h80000037, 3'd3, 32'h80000000, 1'b0, 64'hFFFFFFFF80000000, 1'b0};
      vecs[9]  = '{32'h800000EF, 3'd4, 32'hFFF00000, 1'b0, 64'hFFFFFFFFFFF00000, 1'b0};
      vecs[10] = '{32'h80000063, 3'd2, 32'hFFFFF000, 1'b0, 64'hFFFFFFFFFFFFF000, 1'b0};
      vecs[11] = '{32'hFFFFFFFF, 3'd5, 32'h0000001F, 1'b0, 64'h000000000000001F, 1'b0};
      vecs[12] = '{32'hFFFFFFFF, 3'd6, 32'h0000001F, 1'b1, 64'h000000000000003F, 1'b0};
      vecs[13] = '{32'h7FF00013, 3'd0, 32'h000007FF, 1'b0, 64'h00000000000007FF, 1'b0};
      vecs[14] = '{32'h01F00093, 3'd6, 32'h0000001F, 1'b0, 64'h000000000000001F, 1'b0};

      rst_n = 1'b0;
      v32 = 0; v64 = 0; ve = 0;
      r32 = 1; r64 = 1; re = 1;
      instr = '0; sel = '0; tag = '0;
      step();
      step();
      chk("rst_in_ready_low", {63'b0, ir32}, 64'd0);
      chk("rst_out_valid", {63'b0, ov32}, 64'd0);
      chk("rst_imm", {32'b0, imm32}, 64'd0);
      chk("rst_tag", {59'b0, tag32}, 64'd0);
      chk("rst_err", {63'b0, err32}, 64'd0);
      chk("rst_cnt", {48'b0, cnt32}, 64'd0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", {63'b0, ir32}, 64'd1);

      // Format table, back to back, on both widths.
      for (int i = 0; i < 15; i++) begin
         v32 = 1; v64 = 1;
         instr = vecs[i].instr;
         sel   = vecs[i].sel;
         tag   = 5'(i);
         step();
         if (vecs[i].err32 && exp_cnt32 != 16'hFFFF) exp_cnt32++;
         if (vecs[i].err64 && exp_cnt64 != 16'hFFFF) exp_cnt64++;
         chk($sformatf("v%0d_valid32", i), {63'b0, ov32}, 64'd1);
         chk($sformatf("v%0d_imm32", i), {32'b0, imm32}, {32'b0, vecs[i].exp32});
         chk($sformatf("v%0d_err32", i), {63'b0, err32}, {63'b0, vecs[i].err32});
         chk($sformatf("v%0d_tag32", i), {59'b0, tag32}, 64'(i));
         chk($sformatf("v%0d_cnt32", i), {48'b0, cnt32}, {48'b0, exp_cnt32});
         chk($sformatf("v%0d_valid64", i), {63'b0, ov64}, 64'd1);
         chk($sformatf("v%0d_imm64", i), imm64, vecs[i].exp64);
         chk($sformatf("v%0d_err64", i), {63'b0, err64}, {63'b0, vecs[i].err64});
         chk($sformatf("v%0d_cnt64", i), {48'b0, cnt64}, {48'b0, exp_cnt64});
      end
      v32 = 0; v64 = 0;
      step();
      chk("idle_valid32", {63'b0, ov32}, 64'd0);
      chk("idle_valid64", {63'b0, ov64}, 64'd0);

      // Backpressure: tags 0..7, consumer stalled on cycles 3-6.
      sent = 0;
      recv = 0;
      for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
         cycle(sent < 8, 5'(sent), !(cyc >= 3 && cyc <= 6), acc);
         if (acc) sent++;
      end
      chk("bp_sent", 64'(sent), 64'd8);
      chk("bp_recv", 64'(recv), 64'd8);
      chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);

      // Skid full, then release the consumer while a new word waits.
      cycle(1, 5'd10, 0, acc);
      cycle(1, 5'd11, 0, acc);
      chk("simul_skid_full", {63'b0, ir32}, 64'd0);
      cycle(1, 5'd12, 1, acc);
      chk("simul_not_taken", {63'b0, acc}, 64'd0);
      chk("simul_tag_from_skid", {59'b0, tag32}, 64'd11);
      for (int k = 0; k < 3 && !acc; k++) cycle(1, 5'd12, 1, acc);
      chk("simul_taken", {63'b0, acc}, 64'd1);
      for (int k = 0; k < 5 && exp_q.size() > 0; k++) cycle(0, 5'd0, 1, acc);
      chk("simul_drained", 64'(exp_q.size()), 64'd0);

      // Saturating counter on the narrow-counter instance.
      for (int k = 0; k < 5; k++) begin
         ve = 1;
         sel = 3'b111;
         instr = $urandom;
         tag = 5'(k);
         step();
         chk($sformatf("sat%0d_imm", k), {32'b0, imme}, 64'd0);
         chk($sformatf("sat%0d_err", k), {63'b0, erre}, 64'd1);
         chk($sformatf("sat%0d_cnt", k), {62'b0, cnte}, {62'b0, cnt_exp[k]});
      end
      ve = 0;
      step();

      // Reset with both entries occupied.
      cycle(1, 5'd20, 0, acc);
      cycle(1, 5'd21, 0, acc);
      chk("mid_full", {63'b0, ir32}, 64'd0);
      v32 = 0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", {63'b0, ir32}, 64'd0);
      step();
      rst_n = 1'b1;
      #1;
      chk("mid_out_valid", {63'b0, ov32}, 64'd0);
      chk("mid_in_ready", {63'b0, ir32}, 64'd1);
      chk("mid_cnt", {48'b0, cnt32}, 64'd0);
      chk("mid_imm", {32'b0, imm32}, 64'd0);
      exp_q.delete();
      recv = 0;
      cycle(1, 5'd9, 1, acc);
      cycle(0, 5'd0, 1, acc);
      chk("mid_recv", 64'(recv), 64'd1);
      cycle(0, 5'd0, 1, acc);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
